// File: rtl/rgb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_pkg : colour state encoding and state-to-RGB enable table         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package rgb_pkg;

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_RED     = 3'd1,
      S_YELLOW  = 3'd2,
      S_GREEN   = 3'd3,
      S_CYAN    = 3'd4,
      S_BLUE    = 3'd5,
      S_MAGENTA = 3'd6,
      S_WHITE   = 3'd7
   } color_state_t;

   // Returned vector is {R, G, B}.
   function automatic logic [2:0] state_rgb(input color_state_t s);
      logic [2:0] en;
      case (s)
         S_OFF:     en = 3'b000;
         S_RED:     en = 3'b100;
         S_YELLOW:  en = 3'b110;
         S_GREEN:   en = 3'b010;
         S_CYAN:    en = 3'b011;
         S_BLUE:    en = 3'b001;
         S_MAGENTA: en = 3'b101;
         S_WHITE:   en = 3'b111;
         default:   en = 3'b000;
      endcase
      return en;
   endfunction

   // White wraps to red; off is only re-entered through a long press.
   function automatic color_state_t next_color(input color_state_t s);
      logic [2:0] nxt;
      if (s == S_WHITE) begin
         nxt = 3'(S_RED);
      end else begin
         nxt = 3'(s) + 3'd1;
      end
      return color_state_t'(nxt);
   endfunction

endpackage
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debouncer : 2-flop synchronizer plus consecutive-sample debounce      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module debouncer #(
   parameter int BOUNCE_TICKS = 120_000
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   localparam int CW = (BOUNCE_TICKS > 1) ? $clog2(BOUNCE_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BOUNCE_TICKS - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          out_q;
   logic          out_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The level flips on the BOUNCE_TICKS-th consecutive disagreeing sample.
   always_comb begin
      out_d = out_q;
      cnt_d = '0;
      if (sync2_q != out_q) begin
         if (cnt_q == CNT_LAST) begin
            out_d = ~out_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         out_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= in;
         sync2_q <= sync1_q;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out = out_q;

endmodule
`default_nettype wire

// File: rtl/rgb_mode_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rgb_mode_controller : button-stepped colour FSM with long-press off   |
// | and PWM-dimmed registered RGB drives.  Revision: 1.0                  |
// +----------------------------------------------------------------------+
module rgb_mode_controller #(
   parameter int BOUNCE_TICKS = 120_000,
   parameter int HOLD_TICKS   = 12_000_000,
   parameter int PWM_BITS     = 8,
   parameter int DUTY         = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button,
   output logic       r,
   output logic       g,
   output logic       b,
   output logic [2:0] state
);

   import rgb_pkg::*;

   localparam int HW  = $clog2(HOLD_TICKS + 1);
   localparam int PW1 = PWM_BITS + 1;
   localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [HW-1:0]  HOLD_SAT  = HW'(HOLD_TICKS);
   localparam logic [PW1-1:0] DUTY_W    = PW1'(DUTY);

   logic                level;
   logic                level_q;
   logic                press_q;
   logic                press_d;
   logic                long_press;
   logic [HW-1:0]       hold_q;
   logic [HW-1:0]       hold_d;
   color_state_t        state_q;
   color_state_t        state_d;
   logic [PWM_BITS-1:0] pwm_q;
   logic [2:0]          rgb_en;
   logic                pwm_on;
   logic                r_q;
   logic                g_q;
   logic                b_q;

   debouncer #(
      .BOUNCE_TICKS(BOUNCE_TICKS)
   ) u_debouncer (
      .clk(clk),
      .rst(rst),
      .in (button),
      .out(level)
   );

   assign press_d    = level & ~level_q;
   assign long_press = level && (hold_q == HOLD_LAST);

   // Saturating at HOLD_TICKS keeps one hold to a single long-press event.
   always_comb begin
      hold_d = hold_q;
      if (!level) begin
         hold_d = '0;
      end else if (hold_q != HOLD_SAT) begin
         hold_d = hold_q + HW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      if (long_press) begin
         state_d = S_OFF;
      end else if (press_q) begin
         state_d = next_color(state_q);
      end
   end

   assign rgb_en = state_rgb(state_q);
   assign pwm_on = {1'b0, pwm_q} < DUTY_W;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q <= 1'b0;
         press_q <= 1'b0;
         hold_q  <= '0;
         state_q <= S_OFF;
         pwm_q   <= '0;
         r_q     <= 1'b0;
         g_q     <= 1'b0;
         b_q     <= 1'b0;
      end else begin
         level_q <= level;
         press_q <= press_d;
         hold_q  <= hold_d;
         state_q <= state_d;
         pwm_q   <= pwm_q + PWM_BITS'(1);
         r_q     <= rgb_en[2] & pwm_on;
         g_q     <= rgb_en[1] & pwm_on;
         b_q     <= rgb_en[0] & pwm_on;
      end
   end

   assign r     = r_q;
   assign g     = g_q;
   assign b     = b_q;
   assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_mode_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rgb_mode_controller : directed stimulus, cycle model comparison    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_rgb_mode_controller;

   localparam int B    = 50;
   localparam int H    = 400;
   localparam int PW   = 4;
   localparam int DUTY = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       button = 1'b0;
   logic       r;
   logic       g;
   logic       b;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rgb_mode_controller #(
      .BOUNCE_TICKS(B),
      .HOLD_TICKS  (H),
      .PWM_BITS    (PW),
      .DUTY        (DUTY)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .button(button),
      .r     (r),
      .g     (g),
      .b     (b),
      .state (state)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: button seen two edges late; the accepted level follows a run of
   // B identical late samples; press lands 2 edges after acceptance, off H.
   int lut [8] = '{0, 4, 6, 2, 3, 1, 5, 7};
   int m_h1, m_h2, m_last, m_run, m_acc, m_hi, m_state, m_pwm, m_rgb;

   function automatic int next_col(input int s);
      return (s == 0 || s == 7) ? 1 : s + 1;
   endfunction

   task automatic model_step(input logic bs, input logic rs);
      int lvl;
      int new_rgb;
      if (rs) begin
         m_h1 = 0; m_h2 = 0; m_last = 0; m_run = 0; m_acc = 0;
         m_hi = 0; m_state = 0; m_pwm = 0; m_rgb = 0;
      end else begin
         new_rgb = (m_pwm < DUTY) ? lut[m_state] : 0;
         if (m_acc == 1) begin
            m_hi++;
            if (m_hi == 2) m_state = next_col(m_state);
            if (m_hi == H) m_state = 0;
         end else begin
            m_hi = 0;
         end
         lvl  = m_h2;
         m_h2 = m_h1;
         m_h1 = int'(bs);
         if (lvl == m_last) begin
            m_run++;
         end else begin
            m_run  = 1;
            m_last = lvl;
         end
         if (lvl != m_acc && m_run >= B) m_acc = lvl;
         m_pwm = (m_pwm + 1) % (1 << PW);
         m_rgb = new_rgb;
      end
   endtask

   initial begin
      logic bs, rs;
      int   act;
      forever begin
         @(posedge clk);
         bs = button;
         rs = rst;
         #1;
         model_step(bs, rs);
         act = int'({state, r, g, b});
         check("model_cycle", act, m_state * 8 + m_rgb);
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int exp_seq [10] = '{1, 2, 3, 4, 5, 6, 7, 1, 2, 3};
      int cnt_r;
      int gb_or;

      // Reset and idle
      wait_neg(2);
      check("reset_state", int'(state), 0);
      check("reset_rgb", int'({r, g, b}), 0);
      rst = 1'b0;
      wait_neg(200);
      check("idle_state", int'(state), 0);

      // Clean press: state changes exactly at edge 53
      button = 1'b1;
      wait_neg(53);
      check("press_edge52", int'(state), 0);
      wait_neg(1);
      check("press_edge53", int'(state), 1);
      wait_neg(46);
      button = 1'b0;
      wait_neg(20);
      cnt_r = 0;
      gb_or = 0;
      for (int i = 0; i < 16; i++) begin
         cnt_r += int'(r);
         gb_or |= int'(g | b);
         wait_neg(1);
      end
      check("red_duty_16", cnt_r, 8);
      check("red_gb_off", gb_or, 0);
      wait_neg(64);

      // Bounce rejection
      for (int i = 0; i < 20; i++) begin
         button = ~button;
         wait_neg(20);
      end
      button = 1'b0;
      wait_neg(100);
      check("bounce_state", int'(state), 1);

      // Sequencing and wrap from reset
      rst = 1'b1;
      wait_neg(2);
      rst = 1'b0;
      wait_neg(5);
      for (int i = 0; i < 10; i++) begin
         button = 1'b1;
         wait_neg(100);
         check($sformatf("seq_%0d", i), int'(state), exp_seq[i]);
         button = 1'b0;
         wait_neg(100);
      end

      // Long press from green
      check("pre_long", int'(state), 3);
      button = 1'b1;
      wait_neg(54);
      check("long_first_adv", int'(state), 4);
      wait_neg(397);
      check("long_edge450", int'(state), 4);
      wait_neg(1);
      check("long_edge451", int'(state), 0);
      wait_neg(148);
      check("long_held", int'(state), 0);
      button = 1'b0;
      wait_neg(100);
      check("long_release", int'(state), 0);
      button = 1'b1;
      wait_neg(100);
      button = 1'b0;
      wait_neg(100);
      check("post_long_press", int'(state), 1);

      // Reset in the middle of a debounce
      rst = 1'b1;
      wait_neg(2);
      rst = 1'b0;
      wait_neg(5);
      button = 1'b1;
      wait_neg(30);
      rst = 1'b1;
      wait_neg(2);
      check("midrst_in_reset", int'(state), 0);
      rst = 1'b0;
      wait_neg(53);
      check("midrst_edge52", int'(state), 0);
      wait_neg(1);
      check("midrst_edge53", int'(state), 1);
      button = 1'b0;
      wait_neg(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rgb_mode_controller.md
RGB_MODE_CONTROLLER -- requirements
Module: rgb_mode_controller

Interface
REQ-001 SHALL have parameter BOUNCE_TICKS, default 120_000, the cycles a synchronized button level must hold before it is accepted (>=1).
REQ-002 SHALL have parameter HOLD_TICKS, default 12_000_000, the cycles of accepted-high button that trigger a long press (> BOUNCE_TICKS).
REQ-003 SHALL have parameter PWM_BITS, default 8, the width of the PWM counter.
REQ-004 SHALL have parameter DUTY, default 64, range 0..2^PWM_BITS, giving on-cycles per PWM period.
REQ-005 SHALL have port clk, input, 1 bit: system clock; the block uses one clock only.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port button, input, 1 bit: raw, asynchronous, bouncing, active-high pushbutton.
REQ-008 SHALL have ports r, g and b, output, 1 bit each: PWM-gated LED drives, active-high.
REQ-009 SHALL have port state, output, 3 bits: current colour state encoding, for debug.

Function
REQ-010 SHALL synchronize button through a 2-flop synchronizer before any other use.
REQ-011 SHALL update the accepted level only when the synchronized input differs from the accepted level for BOUNCE_TICKS consecutive cycles; any agreeing sample restarts the count.
REQ-012 SHALL register the accepted level and generate a one-cycle press pulse on its rising edge; a press changes state exactly BOUNCE_TICKS+3 clk edges after the first edge sampling button high.
REQ-013 SHALL implement an FSM with states S_OFF=0, S_RED=1, S_YELLOW=2, S_GREEN=3, S_CYAN=4, S_BLUE=5, S_MAGENTA=6, S_WHITE=7.
REQ-014 SHALL move S_OFF->S_RED on a press pulse, advance each state to the next encoding, and wrap S_WHITE->S_RED (never to S_OFF).
REQ-015 SHALL hold a counter that counts while the accepted level is high and clears while it is low; on the cycle it reaches HOLD_TICKS the FSM SHALL go to S_OFF, and the counter SHALL saturate so that one hold causes exactly one transition.
REQ-016 SHALL stay in S_OFF when a long press occurs in S_OFF; the press pulse that began the hold SHALL still have advanced the state first.
REQ-017 SHALL use the colour enables R/G/B: OFF 000, RED 100, YELLOW 110, GREEN 010, CYAN 011, BLUE 001, MAGENTA 101, WHITE 111.
REQ-018 SHALL run a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0.
REQ-019 SHALL drive each of r, g and b high (registered) only when its colour enable is set and pwm_cnt < DUTY.
REQ-020 SHALL keep all LED outputs low when DUTY=0, and keep enabled colours continuously high when DUTY=2^PWM_BITS.
REQ-021 SHALL drive state from the FSM register with zero added latency.
REQ-022 SHALL ignore releases, which produce no state change.

Reset
REQ-023 SHALL clear asynchronously, on rst high, the synchronizer flops, debounce counter, accepted level (0), hold counter, PWM counter, state (S_OFF) and r/g/b (0).
REQ-024 SHALL abandon any in-progress debounce or hold when rst is asserted mid-operation, and SHALL require a full BOUNCE_TICKS of stable high after rst falls before a held button registers a press.

Structure
REQ-025 SHALL place the color_state_t enum (3-bit) and the state-to-RGB enable function/constant table in shared package rgb_pkg.
REQ-026 SHALL implement the synchronizer plus debounce logic as sub-module debouncer (parameter BOUNCE_TICKS; ports clk, rst, in, out), reusable by other button-driven blocks.

Verification (BOUNCE_TICKS=50, HOLD_TICKS=400, PWM_BITS=4, DUTY=8)
REQ-027 SHALL check reset: assert rst for 2 cycles -> state=0, r=g=b=0; release with button low for 200 cycles -> no change.
REQ-028 SHALL check a clean press: button high 100 cycles, low 100 cycles -> state 0->1 at exactly edge 53 after the first high sample; r toggles 8 on/8 off per 16 cycles; g=b=0.
REQ-029 SHALL check bounce rejection: toggle button every 20 cycles for 400 cycles, then hold low -> state unchanged.
REQ-030 SHALL check sequencing and wrap: 10 clean presses of 100 high / 100 low from reset -> state sequence 1,2,...,7,1,2,3.
REQ-031 SHALL check long press: from state 3, hold button high 600 cycles -> state 4 after the press, then 0 at accepted-high +400 cycles, with no further change until release; the next press gives 1.
REQ-032 SHALL check reset mid-debounce: button high, rst pulsed at cycle 30 of debounce, button kept high -> state=0 until 50 stable cycles after rst falls, then state=1.
